parity_stream_ctrl: RTL

- Sequencer for the two-state serial odd-parity generator. It accepts a parallel WIDTH-bit message over a valid/ready handshake and clears the generator.
- It then shifts the message into the generator MSB-first, one bit per cycle, and captures the generator's final output as the message's odd-parity bit.
- It returns the message plus parity bit over a second valid/ready handshake.
- It replaces ad-hoc stimulus sequencing, so the serial generator can sit inside a framed datapath.

---
 rtl/parity_stream_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/parity_stream_ctrl.sv
// rtl/parity_stream_ctrl.sv - sequencer that frames a serial odd-parity generator behind valid/ready handshakes
//
// Accepts a WIDTH-bit message on in_valid/in_ready and clears the external
// serial parity generator for one cycle. It then shifts the message into the
// generator MSB-first, waits FSM_LAT cycles for the generator result, and
// returns the message with its odd-parity bit on out_valid/out_ready.
//
// Parameters:
//   WIDTH    message width in bits (>= 1)
//   FSM_LAT  cycles from the last serial bit to a valid generator output (>= 1)
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     upstream handshake, in_data parallel message
//   fsm_reset, fsm_in     reset and serial data to the parity generator
//   fsm_out               parity output of the generator
//   out_valid/out_ready   downstream handshake, out_data/out_parity result
//   busy                  high in any state other than IDLE
//   parity_err            (PARITY_STREAM_CHECK_EN only) sticky generator mismatch flag
//
// Build option: define PARITY_STREAM_CHECK_EN to add the parity_err checker.

module parity_stream_ctrl #(
  parameter int WIDTH   = 3,
  parameter int FSM_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             fsm_reset,
  output logic             fsm_in,
  input  logic             fsm_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_parity,
  output logic             busy
`ifdef PARITY_STREAM_CHECK_EN
  ,
  output logic             parity_err
`endif
);

  // Counter widths kept at least one bit so WIDTH=1 / FSM_LAT=1 still elaborate.
  localparam int CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int WAIT_W = (FSM_LAT > 1) ? $clog2(FSM_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    SHIFT = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   shreg;
  logic [CNT_W-1:0]   bit_cnt;
  logic [WAIT_W-1:0]  wait_cnt;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  // Generator is held in reset with the controller and during the CLR cycle.
  assign fsm_reset = reset | (state == CLR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      wait_cnt   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_parity <= 1'b0;
      fsm_in     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          fsm_in <= 1'b0;
          if (in_valid) begin
            shreg    <= in_data;
            out_data <= in_data;
            state    <= CLR;
          end
        end

        CLR: begin
          // fsm_in is registered, so the MSB is launched as CLR is left.
          fsm_in  <= shreg[WIDTH-1];
          shreg   <= shreg << 1;
          bit_cnt <= CNT_W'(WIDTH - 1);
          state   <= SHIFT;
        end

        SHIFT: begin
          if (bit_cnt == '0) begin
            fsm_in   <= 1'b0;
            wait_cnt <= WAIT_W'(FSM_LAT - 1);
            state    <= WAIT;
          end else begin
            fsm_in  <= shreg[WIDTH-1];
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt - 1'b1;
          end
        end

        WAIT: begin
          fsm_in <= 1'b0;
          if (wait_cnt == '0) begin
            out_parity <= fsm_out;
            out_valid  <= 1'b1;
            state      <= DONE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        DONE: begin
          fsm_in <= 1'b0;
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          fsm_in    <= 1'b0;
        end
      endcase
    end
  end

`ifdef PARITY_STREAM_CHECK_EN
  // out_data still holds the accepted message, so its reduction gives the
  // expected odd-parity bit independent of the generator.
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_err <= 1'b0;
    end else if (state == WAIT && wait_cnt == '0 && fsm_out != ~^out_data) begin
      parity_err <= 1'b1;
    end
  end
`endif

endmodule
